// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and the key event record
// used by the PS/2 key event controller and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;

    localparam logic [7:0] PS2_ST_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ST_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ST_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ST_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ST_BATF   = 8'hFC;
    localparam logic [7:0] PS2_ST_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ST_ERR1   = 8'hFF;

    localparam logic [7:0] KEY_UP        = 8'h75;
    localparam logic [7:0] KEY_DOWN      = 8'h72;
    localparam logic [7:0] KEY_LEFT      = 8'h6B;
    localparam logic [7:0] KEY_RIGHT     = 8'h74;
    localparam logic [7:0] KEY_SPACE     = 8'h29;
    localparam logic [7:0] KEY_ENTER     = 8'h5A;

    // Bytes following E1 in the pause sequence (E1 14 77 E1 F0 14 F0 77)
    localparam logic [2:0] PAUSE_SKIP    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_evt_t;

    function automatic logic is_status(input logic [7:0] b);
        return b inside {PS2_ST_ERR0, PS2_ST_BAT, PS2_ST_ECHO, PS2_ST_ACK,
                         PS2_ST_BATF, PS2_ST_RESEND, PS2_ST_ERR1};
    endfunction

    function automatic logic [5:0] key_mask(input key_evt_t e);
        logic [5:0] m;
        m = '0;
        case ({e.ext, e.code})
            {1'b1, KEY_UP}:    m = 6'b000001;
            {1'b1, KEY_DOWN}:  m = 6'b000010;
            {1'b1, KEY_LEFT}:  m = 6'b000100;
            {1'b1, KEY_RIGHT}: m = 6'b001000;
            {1'b0, KEY_SPACE}: m = 6'b010000;
            {1'b0, KEY_ENTER}: m = 6'b100000;
            default:           m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through key event FIFO; head visible the cycle after the write.
// Full without a pop drops the write and flags it on drop_o; empty ignores rd_rdy_i.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld_i,
    input  key_evt_t                 wr_dat_i,
    output logic                     rd_vld_o,
    input  logic                     rd_rdy_i,
    output key_evt_t                 rd_dat_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);

    key_evt_t      mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = rd_rdy_i & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push   = wr_vld_i & (~full | pop);
    assign drop_o = wr_vld_i & full & ~pop;

    assign rd_vld_o = ~empty;
    assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o  = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: prefix decode, held-key bitmap, FIFO of key events.
// Latency: event visible one cycle after its final byte; full FIFO drops and sets overflow.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [7:0]                   evt_code,
    output logic                         evt_ext,
    output logic                         evt_release,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [5:0]                   key_held
);
    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    dec_state_t  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [TW-1:0] tmo_q;
    logic [5:0]  held_q, held_d;
    logic        ovf_q;
    logic        emit;
    key_evt_t    evt_d;
    key_evt_t    head;
    logic        drop;
    logic [5:0]  mask;

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        emit       = 1'b0;
        evt_d      = '0;
        evt_d.code = byte_in;
        if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_in == PS2_EXT)        state_d = ST_EXT;
                    else if (byte_in == PS2_BRK)   state_d = ST_BRK;
                    else if (byte_in == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_status(byte_in)) emit = 1'b1;
                end
                ST_EXT: begin
                    if (byte_in == PS2_BRK)        state_d = ST_EXT_BRK;
                    else if (byte_in != PS2_EXT) begin
                        emit      = 1'b1;
                        evt_d.ext = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (byte_in != PS2_BRK) begin
                        emit      = 1'b1;
                        evt_d.rel = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    emit      = 1'b1;
                    evt_d.ext = 1'b1;
                    evt_d.rel = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            skip_d  = '0;
        end
    end

    // The bitmap tracks every decoded event, including ones the FIFO drops.
    always_comb begin
        mask   = key_mask(evt_d);
        held_d = held_q;
        if (emit) held_d = evt_d.rel ? (held_q & ~mask) : (held_q | mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            held_q  <= held_d;
            if (byte_valid)           tmo_q <= '0;
            else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + TW'(1);
            if (drop)                 ovf_q <= 1'b1;
            else if (ovf_clr)         ovf_q <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (emit),
        .wr_dat_i (evt_d),
        .rd_vld_o (evt_valid),
        .rd_rdy_i (evt_ready),
        .rd_dat_o (head),
        .level_o  (fifo_level),
        .drop_o   (drop)
    );

    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_release = head.rel;
    assign overflow    = ovf_q;
    assign key_held    = held_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: a vector table for decode/bitmap/FIFO
// behaviour plus hand-written overflow, timeout and reset sequences.
module tb_ps2_key_event_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic [5:0] key_held;

    int passed = 0;
    int total  = 0;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_release(evt_release), .fifo_level(fifo_level),
        .overflow(overflow), .ovf_clr(ovf_clr), .key_held(key_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       rdy;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [5:0] held;
        logic [2:0] lvl;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic bv, input logic [7:0] b, input logic rdy,
                       input logic ev, input logic [7:0] code, input logic ext,
                       input logic rel, input logic [5:0] held, input logic [2:0] lvl);
        vec_t v;
        v.bv = bv; v.b = b; v.rdy = rdy; v.ev = ev; v.code = code;
        v.ext = ext; v.rel = rel; v.held = held; v.lvl = lvl;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        byte_in = b; byte_valid = 1'b1; evt_ready = rdy;
        tick();
        byte_valid = 1'b0; evt_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0; evt_ready = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_head(input string name, input logic [7:0] code, input logic ext, input logic rel);
        chk({name, "_vld"}, evt_valid, 1'b1);
        chk({name, "_evt"}, {evt_code, evt_ext, evt_release}, {code, ext, rel});
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_codes[4];

        rst = 1'b1; byte_in = 8'h1C; byte_valid = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_vld",   evt_valid, 1'b0);
        chk("rst_evt",   {evt_code, evt_ext, evt_release}, 10'h0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ovf",   overflow, 1'b0);
        chk("rst_held",  key_held, 6'h00);
        rst = 1'b0; byte_valid = 1'b0;
        tick();
        chk("rst_nobyte_level", fifo_level, 3'd0);

        //   bv  byte  rdy ev code  ext rel held       lvl
        add(1, 8'h1C, 0, 1, 8'h1C, 0, 0, 6'b000000, 1);
        add(1, 8'hF0, 1, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 6'b000000, 1);
        add(1, 8'hE0, 1, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h75, 0, 1, 8'h75, 1, 0, 6'b000001, 1);
        add(1, 8'hE0, 1, 0, 8'h00, 0, 0, 6'b000001, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b000001, 0);
        add(1, 8'h75, 0, 1, 8'h75, 1, 1, 6'b000000, 1);
        add(1, 8'hAA, 1, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'hFA, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'hE1, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h14, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h77, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'hE1, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h14, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h77, 0, 0, 8'h00, 0, 0, 6'b000000, 0);
        add(1, 8'h29, 0, 1, 8'h29, 0, 0, 6'b010000, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b010000, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 6'b010000, 0);
        add(1, 8'h72, 0, 1, 8'h72, 1, 0, 6'b010010, 1);
        add(1, 8'h5A, 0, 1, 8'h72, 1, 0, 6'b110010, 2);
        add(0, 8'h00, 1, 1, 8'h5A, 0, 0, 6'b110010, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b110010, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b110010, 0);
        add(1, 8'h29, 0, 1, 8'h29, 0, 1, 6'b100010, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b100010, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 6'b100010, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 6'b100010, 0);
        add(1, 8'h74, 0, 1, 8'h74, 1, 0, 6'b101010, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'hF0, 0, 1, 8'hF0, 1, 1, 6'b101010, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 6'b101010, 0);
        add(1, 8'h72, 0, 1, 8'h72, 1, 1, 6'b101000, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b101000, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 6'b101000, 0);

        foreach (vt[i]) begin
            byte_valid = vt[i].bv; byte_in = vt[i].b; evt_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_vld", i), evt_valid, vt[i].ev);
            if (vt[i].ev)
                chk($sformatf("vec%0d_evt", i), {evt_code, evt_ext, evt_release},
                    {vt[i].code, vt[i].ext, vt[i].rel});
            chk($sformatf("vec%0d_held", i), key_held, vt[i].held);
            chk($sformatf("vec%0d_lvl", i), fifo_level, vt[i].lvl);
        end
        byte_valid = 1'b0; evt_ready = 1'b0;

        // Overflow: five back-to-back makes into a depth-4 FIFO
        send(8'h11, 0); send(8'h12, 0); send(8'h13, 0);
        byte_in = 8'h14; byte_valid = 1'b1;
        tick();
        chk("ovf_before_drop", overflow, 1'b0);
        chk("ovf_full_level", fifo_level, 3'd4);
        byte_in = 8'h15;
        tick();
        byte_valid = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_level", fifo_level, 3'd4);
        byte_in = 8'h16; byte_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        byte_valid = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        exp_codes[0] = 8'h11; exp_codes[1] = 8'h12; exp_codes[2] = 8'h13; exp_codes[3] = 8'h14;
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("drain%0d", i), exp_codes[i], 1'b0, 1'b0);
            pop_one();
        end
        chk("drain_empty", evt_valid, 1'b0);
        chk("drain_level", fifo_level, 3'd0);

        // Full FIFO with simultaneous push and pop
        send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
        send(8'h25, 1);
        chk("pushpop_level", fifo_level, 3'd4);
        chk("pushpop_ovf", overflow, 1'b0);
        exp_codes[0] = 8'h22; exp_codes[1] = 8'h23; exp_codes[2] = 8'h24; exp_codes[3] = 8'h25;
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("pp_drain%0d", i), exp_codes[i], 1'b0, 1'b0);
            pop_one();
        end
        chk("pp_empty", evt_valid, 1'b0);

        // Timeout boundary: TMO-1 idle cycles keeps the prefix, TMO idle cycles drops it
        send(8'hE0, 0);
        idle(TMO - 1);
        send(8'h1C, 0);
        chk_head("tmo_inside", 8'h1C, 1'b1, 1'b0);
        pop_one();
        send(8'hE0, 0);
        idle(TMO);
        chk("tmo_no_event", fifo_level, 3'd0);
        send(8'h6B, 0);
        chk_head("tmo_expired", 8'h6B, 1'b0, 1'b0);
        chk("tmo_left_held", key_held[2], 1'b0);
        chk("tmo_ovf", overflow, 1'b0);
        pop_one();

        // Reset in the middle of a break sequence with a full, overflowed FIFO
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 0);
        chk("pre_rst_ovf", overflow, 1'b1);
        send(8'hE0, 0); send(8'hF0, 0);
        rst = 1'b1; byte_in = 8'h75; byte_valid = 1'b1;
        tick();
        rst = 1'b0; byte_valid = 1'b0;
        chk("mid_rst_vld",   evt_valid, 1'b0);
        chk("mid_rst_evt",   {evt_code, evt_ext, evt_release}, 10'h0);
        chk("mid_rst_level", fifo_level, 3'd0);
        chk("mid_rst_ovf",   overflow, 1'b0);
        chk("mid_rst_held",  key_held, 6'h00);
        send(8'h75, 0);
        chk_head("post_rst_make", 8'h75, 1'b0, 1'b0);
        chk("post_rst_held", key_held, 6'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

- Sequences the raw PS/2 scan-code byte stream from the keyboard receiver into discrete key events for the game logic.
- Decodes the 0xE0 (extended), 0xF0 (break) and 0xE1 (pause) prefixes, drops controller status bytes and aborts stale prefixes on timeout.
- Buffers completed events in a small FIFO with a valid/ready handshake.
- Maintains a live held-key bitmap for the console's six game controls.

## Interface
Parameters:
- FIFO_DEPTH, 4 — event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 2_000_000 — idle clocks after which a partial prefix sequence is discarded (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  received scan-code byte; sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_code  out  8  head event scan code, prefix stripped.
- evt_ext  out  1  head event carried the 0xE0 prefix.
- evt_release  out  1  head event is a break (1) or a make (0).
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- ovf_clr  in  1  clears overflow; if ovf_clr and a new drop occur in the same cycle, the set wins.
- key_held  out  6  bit0 up (E0 75), bit1 down (E0 72), bit2 left (E0 6B), bit3 right (E0 74), bit4 space (29), bit5 enter (5A).

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions happen only on byte_valid, except the timeout.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - E1 -> SKIP with skip counter = 7.
  - 00, AA, EE, FA, FC, FE, FF are dropped; state stays IDLE.
  - Any other byte emits a make event {code, ext=0, rel=0}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 stays EXT.
  - Other byte emits {code, ext=1, rel=0} -> IDLE.
- BRK: F0 stays BRK; any other byte emits {code, ext=0, rel=1} -> IDLE.
- EXT_BRK: emits {code, ext=1, rel=1} -> IDLE. Prefix bytes (E0/F0) in this state are emitted as codes; no special casing.
- SKIP: consumes bytes without emitting and decrements the counter. The 7th swallowed byte returns the FSM to IDLE.
- Timeout: idle counter clears on every byte_valid. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE. No event is emitted and overflow is unaffected.
- key_held is updated on every emitted event whose {ext, code} matches a control key: make sets the bit, break clears it. The update happens even if the FIFO drops the event.
- FIFO is first-word-fall-through; evt_* fields are driven from the head entry.
  - Pop when evt_valid & evt_ready.
  - Push when an event is emitted.
  - When full: push without pop drops the new event and sets overflow. Push with a simultaneous pop performs both; the level is unchanged.
  - When empty: evt_ready is ignored.
- Reset values: FSM IDLE, skip and timeout counters 0, FIFO empty, evt_valid 0, evt_code/evt_ext/evt_release 0, fifo_level 0, overflow 0, key_held 0.
- Reset asserted mid-sequence or with a full FIFO discards everything. Bytes presented while rst=1 are ignored.

## Timing
- Decode is combinational from byte_in and state. FSM, FIFO write and key_held update on the edge ending the byte_valid cycle (N).
- If the FIFO was empty, evt_valid=1 in cycle N+1 with the event on evt_*. key_held reflects the event in N+1.
- Pop at the edge of the handshake cycle; the next entry, if any, appears in the following cycle.
- Back-to-back byte_valid on consecutive cycles must be supported: one byte per clock.
- Timeout fires exactly TIMEOUT_CYCLES clocks after the last byte. Counter width is clog2(TIMEOUT_CYCLES).
- overflow sets in cycle N+1 after the dropping push.

## Structure
- Shared package ps2_pkg holds:
  - scan-code constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, status codes, the six control-key codes;
  - decoder state enum;
  - key_evt_t struct {code[7:0], ext, rel}.
- One sub-module, ps2_evt_fifo: FWFT, parameterised depth, read/write pointers with an extra wrap bit, exported level. The decoder and key_held logic live in the top block.

## Test plan
- Feed 1C, then F0 1C -> event {1C,0,0}, then event {1C,0,1}. Each evt_valid appears 1 cycle after its final byte.
- Feed E0 75, then E0 F0 75 -> key_held[0] goes 1 then 0. Events {75,1,0} and {75,1,1}.
- Feed AA, FA, then E1 14 77 E1 F0 14 F0 77, then 29 -> only {29,0,0} is emitted; key_held[4]=1.
- Hold evt_ready=0 and feed 5 make codes (depth 4) -> fifo_level=4, overflow=1, 5th code lost. Pulse ovf_clr -> overflow=0. Drain returns the first 4 codes in order.
- Feed E0, wait TIMEOUT_CYCLES, feed 6B -> event {6B,0,0}, key_held[2] stays 0.
- With the FIFO full, push and pop in the same cycle -> level stays 4, overflow stays 0. Assert rst mid E0 F0 sequence -> all outputs return to reset values.
